packet_dispatch_sched: RTL and testbench

Schedules whole packets from one stream onto NUM_OUT worker channels, ahead of the 1-to-N tree packet arbiter. It picks an idle worker round-robin, writes the worker id into the ctl field that the downstream tree uses for routing, and locks the stream to that worker for the whole packet. It marks the worker busy until that worker pulses its done line. This keeps one packet in flight per worker and hides worker occupancy from the upstream source.

---
 rtl/packet_dispatch_sched_if.sv | 21 ++
 rtl/packet_dispatch_sched.sv | 167 ++++++++++++++++
 tb/tb_packet_dispatch_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_dispatch_sched_if.sv
// Valid/ready packet stream bundle shared by the dispatcher and its neighbours.
interface if_axi_stream #(
    parameter int unsigned DAT_BYTS = 8,
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned DAT_BITS = DAT_BYTS * 8,
    parameter int unsigned MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS)
) ();

    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [MOD_BITS-1:0] mod;
    logic [CTL_BITS-1:0] ctl;

    modport sink   (input  val, sop, eop, err, dat, mod, ctl, output rdy);
    modport source (output val, sop, eop, err, dat, mod, ctl, input  rdy);

endinterface

// File: rtl/packet_dispatch_sched.sv
// Packet dispatcher: picks an idle worker round-robin, tags the ctl field with
// its id and holds the stream on that worker until eop. A worker stays busy
// until it pulses its done line.
module packet_dispatch_sched #(
    parameter int unsigned DAT_BYTS     = 8,
    parameter int unsigned DAT_BITS     = DAT_BYTS * 8,
    parameter int unsigned CTL_BITS     = 8,
    parameter int unsigned NUM_OUT      = 8,
    parameter int unsigned LOG2_NUM_OUT = (NUM_OUT == 1) ? 1 : $clog2(NUM_OUT),
    parameter int unsigned OVR_WRT_BIT  = CTL_BITS - LOG2_NUM_OUT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    if_axi_stream.sink         i_axi,
    if_axi_stream.source       o_axi,
    input  logic [NUM_OUT-1:0] i_done,
    output logic [NUM_OUT-1:0] o_busy,
    output logic               o_err
);

    localparam int unsigned       ID_W    = LOG2_NUM_OUT;
    localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_OUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic [ID_W-1:0]     sel_q,    sel_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_OUT-1:0]  busy_q,   busy_d;
    logic                err_q,    err_d;
    logic                first_q,  first_d;

    logic [ID_W-1:0]     free_id_c;
    logic                free_vld_c;
    logic [NUM_OUT-1:0]  busy_set_c;
    logic                in_rdy_c;
    logic                out_val_c;
    logic                xfer_c;
    logic [DAT_BITS-1:0] dat_c;
    logic [CTL_BITS-1:0] ctl_c;

    // First free worker at or above rr_ptr, wrapping at NUM_OUT
    always_comb begin
        int unsigned        idx;
        logic [NUM_OUT-1:0] rot;
        idx        = 0;
        rot        = '0;
        free_vld_c = 1'b0;
        free_id_c  = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_OUT) begin
                idx = idx - NUM_OUT;
            end
            rot = busy_q >> idx;
            if (!free_vld_c && !rot[0]) begin
                free_vld_c = 1'b1;
                free_id_c  = ID_W'(idx);
            end
        end
    end

    // Payload pass-through with the worker id written into the ctl field
    always_comb begin
        dat_c = i_axi.dat;
        ctl_c = i_axi.ctl;
        ctl_c[OVR_WRT_BIT +: ID_W] = sel_q;
        o_axi.dat = dat_c;
        o_axi.ctl = ctl_c;
        o_axi.sop = i_axi.sop;
        o_axi.eop = i_axi.eop;
        o_axi.err = i_axi.err;
        o_axi.mod = i_axi.mod;
    end

    // Handshake steering: idle drops stray non-sop beats, send is zero-latency
    always_comb begin
        out_val_c = 1'b0;
        in_rdy_c  = 1'b0;
        if (!i_rst) begin
            case (state_q)
                ST_IDLE: in_rdy_c = i_axi.val && !i_axi.sop;
                ST_SEND: begin
                    out_val_c = i_axi.val;
                    in_rdy_c  = o_axi.rdy;
                end
                default: ;
            endcase
        end
    end

    assign o_axi.val = out_val_c;
    assign i_axi.rdy = in_rdy_c;
    assign xfer_c    = i_axi.val && in_rdy_c;

    // Next-state: worker selection, packet lock, busy bookkeeping, error flag
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        first_d    = first_q;
        err_d      = err_q;
        busy_set_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_axi.val) begin
                    if (i_axi.sop) begin
                        if (free_vld_c) begin
                            sel_d   = free_id_c;
                            first_d = 1'b1;
                            state_d = ST_SEND;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (xfer_c) begin
                    first_d = 1'b0;
                    if (i_axi.sop && !first_q) begin
                        err_d = 1'b1;
                    end
                    if (i_axi.eop) begin
                        busy_set_c = NUM_OUT'(1) << sel_q;
                        rr_ptr_d   = (sel_q == LAST_ID) ? '0 : sel_q + ID_W'(1);
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Setting busy wins over a same-cycle done for that worker
        busy_d = (busy_q & ~i_done) | busy_set_c;
        if (|(i_done & ~busy_q & ~busy_set_c)) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end

    assign o_busy = busy_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_packet_dispatch_sched.sv
// Bench for packet_dispatch_sched with five workers (id field is ctl[7:5]).
module tb_packet_dispatch_sched;

    localparam int unsigned NO = 5;
    localparam int unsigned DB = 8;
    localparam int unsigned CB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NO-1:0] done;
    logic [NO-1:0] busy;
    logic          err;

    always #5 clk = ~clk;

    if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB)) s_in  ();
    if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB)) s_out ();

    packet_dispatch_sched #(
        .DAT_BYTS (DB),
        .CTL_BITS (CB),
        .NUM_OUT  (NO)
    ) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_axi  (s_in),
        .o_axi  (s_out),
        .i_done (done),
        .o_busy (busy),
        .o_err  (err)
    );

    int n_vec;
    int n_err;
    int pkt_tag;

    typedef struct {
        logic [NO-1:0] done_m;
        int            len;
        logic [7:0]    ctl;
        bit            tog;
        int            id;
        logic [NO-1:0] busy_e;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected tagged ctl: id in bits [7:5], low bits untouched
    function automatic logic [7:0] tag(input logic [7:0] c, input int id);
        return {3'(id), c[4:0]};
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        s_in.val  = 1'b0;
        s_in.sop  = 1'b0;
        s_in.eop  = 1'b0;
        done      = '0;
        s_out.rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_done(input logic [NO-1:0] m);
        done = m;
        @(posedge clk); #1;
        done = '0;
    endtask

    // Send one packet from idle; checks gap cycle, tag, data order and rdy mirroring
    task automatic send_pkt(input int len, input logic [7:0] c, input bit tog,
                            input logic [NO-1:0] dmask, input int id);
        int beat = 0;
        int cyc  = 0;
        int rx   = 0;
        bit hs;
        pkt_tag++;
        s_in.val = 1'b1;
        s_in.sop = 1'b1;
        s_in.eop = (len == 1);
        s_in.ctl = c;
        s_in.dat = {32'(pkt_tag), 32'(0)};
        s_in.err = 1'b0;
        s_in.mod = '0;
        while (beat < len && cyc < 64) begin
            s_out.rdy = tog ? (cyc % 2 == 1) : 1'b1;
            done = (cyc > 0 && s_in.eop && s_out.rdy) ? dmask : '0;
            @(negedge clk);
            if (cyc == 0) chk("gap_val", 64'(s_out.val), 64'(0));
            if (s_out.val) chk("rdy_mirror", 64'(s_in.rdy), 64'(s_out.rdy));
            if (s_out.val && s_out.rdy) begin
                chk("ctl_id", 64'(s_out.ctl), 64'(tag(c, id)));
                chk("dat_seq", s_out.dat, {32'(pkt_tag), 32'(rx)});
                rx++;
            end
            hs = s_in.val && s_in.rdy;
            @(posedge clk); #1;
            done = '0;
            if (hs) begin
                beat++;
                s_in.sop = 1'b0;
                s_in.eop = (beat == len - 1);
                s_in.dat = {32'(pkt_tag), 32'(beat)};
            end
            cyc++;
        end
        s_in.val  = 1'b0;
        s_in.eop  = 1'b0;
        s_out.rdy = 1'b1;
        chk("pkt_done", 64'(beat), 64'(len));
        chk("beats_rx", 64'(rx), 64'(len));
    endtask

    task automatic stall_check();
        s_in.val = 1'b1;
        s_in.sop = 1'b1;
        s_in.eop = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_irdy", 64'(s_in.rdy), 64'(0));
            chk("stall_oval", 64'(s_out.val), 64'(0));
        end
        @(posedge clk); #1;
        s_in.val = 1'b0;
        s_in.eop = 1'b0;
    endtask

    // Random traffic against a packet-level reference of the dispatch rules
    task automatic run_random(input int ncyc);
        logic [NO-1:0] m_busy = '0;
        int m_rr = 0, m_sel = 0, s_len = 0, s_beat = 0, set_k, k;
        bit m_err = 0, m_act = 0, m_first = 0, s_pkt = 0, s_garb = 0;
        bit exp_val, exp_rdy, hs_m, hs_a, found;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (!s_in.val) begin
                if (s_pkt) begin
                    if ($urandom_range(0, 3) != 0) s_in.val = 1'b1;
                end else if ($urandom_range(0, 1) == 0) begin
                    s_in.ctl = 8'($urandom);
                    s_in.dat = {$urandom, $urandom};
                    s_in.err = 1'($urandom);
                    s_in.mod = 3'($urandom);
                    if ($urandom_range(0, 9) == 0) begin
                        s_garb   = 1'b1;
                        s_in.sop = 1'b0;
                        s_in.eop = 1'($urandom);
                    end else begin
                        s_pkt    = 1'b1;
                        s_len    = $urandom_range(1, 4);
                        s_beat   = 0;
                        s_in.sop = 1'b1;
                        s_in.eop = (s_len == 1);
                    end
                    s_in.val = 1'b1;
                end
            end
            s_out.rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                done = NO'($urandom) & (($urandom_range(0, 15) == 0) ? {NO{1'b1}} : m_busy);
            else
                done = '0;

            @(negedge clk);
            exp_val = m_act && s_in.val;
            exp_rdy = m_act ? s_out.rdy : (s_in.val && !s_in.sop);
            chk("r_oval", 64'(s_out.val), 64'(exp_val));
            chk("r_irdy", 64'(s_in.rdy), 64'(exp_rdy));
            chk("r_busy", 64'(busy), 64'(m_busy));
            chk("r_err", 64'(err), 64'(m_err));
            if (exp_val) begin
                chk("r_ctl", 64'(s_out.ctl), 64'(tag(s_in.ctl, m_sel)));
                chk("r_dat", s_out.dat, s_in.dat);
                chk("r_flags", 64'({s_out.sop, s_out.eop, s_out.err, s_out.mod}),
                    64'({s_in.sop, s_in.eop, s_in.err, s_in.mod}));
            end

            hs_m  = s_in.val && exp_rdy;
            set_k = -1;
            if (!m_act) begin
                if (s_in.val && s_in.sop) begin
                    found = 1'b0;
                    for (int j = 0; j < NO; j++) begin
                        k = (m_rr + j) % NO;
                        if (!found && !m_busy[k]) begin
                            found = 1'b1;
                            m_sel = k;
                        end
                    end
                    if (found) begin
                        m_act   = 1'b1;
                        m_first = 1'b1;
                    end
                end else if (s_in.val) begin
                    m_err = 1'b1;
                end
            end else if (hs_m) begin
                if (s_in.sop && !m_first) m_err = 1'b1;
                m_first = 1'b0;
                if (s_in.eop) begin
                    set_k = m_sel;
                    m_rr  = (m_sel + 1) % NO;
                    m_act = 1'b0;
                end
            end
            for (int j = 0; j < NO; j++) begin
                if (done[j]) begin
                    if (!m_busy[j] && j != set_k) m_err = 1'b1;
                    m_busy[j] = 1'b0;
                end
            end
            if (set_k >= 0) m_busy[set_k] = 1'b1;

            hs_a = s_in.val && s_in.rdy;
            @(posedge clk); #1;
            if (hs_a) begin
                if (s_garb) begin
                    s_garb   = 1'b0;
                    s_in.val = 1'b0;
                end else begin
                    s_beat++;
                    if (s_beat == s_len) begin
                        s_pkt    = 1'b0;
                        s_in.val = 1'b0;
                    end else begin
                        s_in.sop = ($urandom_range(0, 15) == 0);
                        s_in.eop = (s_beat == s_len - 1);
                        s_in.dat = {$urandom, $urandom};
                        s_in.ctl = 8'($urandom);
                        s_in.val = ($urandom_range(0, 3) != 0);
                    end
                end
            end
        end
        s_in.val = 1'b0;
        done     = '0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        pkt_tag = 0;

        tbl[0]  = '{5'b00000, 3, 8'h00, 1'b0, 0, 5'b00001};
        tbl[1]  = '{5'b00000, 3, 8'hFF, 1'b0, 1, 5'b00011};
        tbl[2]  = '{5'b00000, 1, 8'h5A, 1'b0, 2, 5'b00111};
        tbl[3]  = '{5'b00000, 3, 8'h00, 1'b0, 3, 5'b01111};
        tbl[4]  = '{5'b00000, 2, 8'hE3, 1'b0, 4, 5'b11111};
        tbl[5]  = '{5'b00100, 3, 8'h11, 1'b0, 2, 5'b11111};
        tbl[6]  = '{5'b01001, 3, 8'h00, 1'b0, 3, 5'b11110};
        tbl[7]  = '{5'b00000, 3, 8'h1F, 1'b0, 0, 5'b11111};
        tbl[8]  = '{5'b11111, 4, 8'hA5, 1'b1, 1, 5'b00010};
        tbl[9]  = '{5'b00010, 2, 8'h07, 1'b0, 2, 5'b00100};
        tbl[10] = '{5'b00000, 1, 8'hC0, 1'b0, 3, 5'b01100};
        tbl[11] = '{5'b00000, 1, 8'h3E, 1'b0, 4, 5'b11100};
        tbl[12] = '{5'b00000, 1, 8'h81, 1'b0, 0, 5'b11101};

        // Reset values, with a stray beat present that must not be accepted
        rst       = 1'b1;
        done      = '0;
        s_out.rdy = 1'b1;
        s_in.val  = 1'b1;
        s_in.sop  = 1'b0;
        s_in.eop  = 1'b0;
        s_in.err  = 1'b0;
        s_in.mod  = '0;
        s_in.ctl  = '0;
        s_in.dat  = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_irdy", 64'(s_in.rdy), 64'(0));
        chk("rst_oval", 64'(s_out.val), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        @(posedge clk); #1;
        s_in.val = 1'b0;
        rst      = 1'b0;

        // Directed round-robin table
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].done_m != '0) pulse_done(tbl[i].done_m);
            send_pkt(tbl[i].len, tbl[i].ctl, tbl[i].tog, '0, tbl[i].id);
            @(negedge clk);
            chk("busy_after", 64'(busy), 64'(tbl[i].busy_e));
            @(posedge clk); #1;
            if (i == 4) stall_check();
        end
        @(negedge clk);
        chk("tbl_err", 64'(err), 64'(0));
        @(posedge clk); #1;

        // Done for a worker in the same cycle its eop sets it busy
        do_reset();
        send_pkt(2, 8'h00, 1'b0, '0, 0);
        send_pkt(3, 8'h00, 1'b0, 5'b00010, 1);
        @(negedge clk);
        chk("eop_done_busy", 64'(busy), 64'(5'b00011));
        chk("eop_done_err", 64'(err), 64'(0));
        @(posedge clk); #1;
        pulse_done(5'b01000);
        @(negedge clk);
        chk("idle_done_err", 64'(err), 64'(1));
        chk("idle_done_busy", 64'(busy), 64'(5'b00011));
        @(posedge clk); #1;

        // Non-sop beat while idle is dropped
        do_reset();
        s_in.val = 1'b1;
        s_in.sop = 1'b0;
        s_in.eop = 1'b1;
        @(negedge clk);
        chk("drop_irdy", 64'(s_in.rdy), 64'(1));
        chk("drop_oval", 64'(s_out.val), 64'(0));
        @(posedge clk); #1;
        s_in.val = 1'b0;
        s_in.eop = 1'b0;
        @(negedge clk);
        chk("drop_err", 64'(err), 64'(1));
        @(posedge clk); #1;
        send_pkt(1, 8'h42, 1'b0, '0, 0);

        // Reset on beat 2 of a 4-beat packet
        do_reset();
        send_pkt(2, 8'h00, 1'b0, '0, 0);
        pulse_done(5'b01000);
        s_in.val = 1'b1;
        s_in.sop = 1'b1;
        s_in.eop = 1'b0;
        s_in.ctl = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_in.sop = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_cut", 64'(s_out.val), 64'(0));
        chk("rst_mid_pre_err", 64'(err), 64'(1));
        @(posedge clk); #1;
        rst      = 1'b0;
        s_in.val = 1'b0;
        @(negedge clk);
        chk("rst_mid_val", 64'(s_out.val), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_err", 64'(err), 64'(0));
        @(posedge clk); #1;
        send_pkt(2, 8'h3C, 1'b0, '0, 0);

        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
